// File: rtl/ski_fetch_service_pkg.sv
// Shared types and helpers for the SKI heap-fetch stage: slot/frame layout,
// tag codes and FSM state encoding.
package ski_fetch_service_pkg;

  localparam int unsigned PTR_W   = 32;
  localparam int unsigned DATA_W  = 63;
  localparam int unsigned SLOT_W  = DATA_W + 2;
  localparam int unsigned NSLOT   = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned FRAME_W = NSLOT * SLOT_W;

  localparam logic [1:0] TAG_EMPTY = 2'b00;
  localparam logic [1:0] TAG_PEND  = 2'b01;
  localparam logic [1:0] TAG_FILL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [1:0]        tag;
    logic [DATA_W-1:0] payload;
  } slot_t;

  // Slot k sits at bits [(k+1)*SLOT_W-1 : k*SLOT_W], matching the flat port layout.
  typedef slot_t [NSLOT-1:0] frame_t;

  function automatic logic [PTR_W-1:0] slot_ptr(input logic [DATA_W-1:0] payload);
    return PTR_W'(payload);
  endfunction

  function automatic logic [NSLOT-1:0] pend_mask(input frame_t frame);
    logic [NSLOT-1:0] m;
    m = '0;
    for (int k = 0; k < int'(NSLOT); k++) begin
      m[k] = (frame[k].tag == TAG_PEND);
    end
    return m;
  endfunction

endpackage

// File: rtl/ski_fetch_service_if.sv
// Frame-in, heap-read and frame-out handshakes of the fetch stage.
interface ski_fetch_service_if;
  import ski_fetch_service_pkg::*;

  logic              req_valid_i;
  frame_t            req_frame_i;
  logic              req_ready_o;
  logic              mem_rd_valid_o;
  logic [PTR_W-1:0]  mem_rd_addr_o;
  logic              mem_rd_ready_i;
  logic              mem_rsp_valid_i;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic              out_valid_o;
  frame_t            out_frame_o;
  logic              out_ready_i;
  logic              busy_o;
  logic              stray_rsp_o;

  modport slave (
    input  req_valid_i, req_frame_i, mem_rd_ready_i, mem_rsp_valid_i,
           mem_rsp_data_i, out_ready_i,
    output req_ready_o, mem_rd_valid_o, mem_rd_addr_o, out_valid_o,
           out_frame_o, busy_o, stray_rsp_o
  );

  modport master (
    output req_valid_i, req_frame_i, mem_rd_ready_i, mem_rsp_valid_i,
           mem_rsp_data_i, out_ready_i,
    input  req_ready_o, mem_rd_valid_o, mem_rd_addr_o, out_valid_o,
           out_frame_o, busy_o, stray_rsp_o
  );

endinterface

// File: rtl/ski_fetch_service_prio_pick.sv
// Lowest-set-bit priority encoder over the 4 pending-slot flags.
module ski_prio_pick (
  input  logic [3:0] i_req,
  output logic [1:0] o_idx_c,
  output logic       o_any_c
);

  always_comb begin
    o_idx_c = 2'd0;
    o_any_c = |i_req;
    casez (i_req)
      4'b???1: o_idx_c = 2'd0;
      4'b??10: o_idx_c = 2'd1;
      4'b?100: o_idx_c = 2'd2;
      4'b1000: o_idx_c = 2'd3;
      default: o_idx_c = 2'd0;
    endcase
  end

endmodule

// File: rtl/ski_fetch_service.sv
// Heap-fetch stage: reads one heap word per pending slot (lowest index first),
// marks the slot filled, then hands the completed frame to the service stage.
module ski_fetch_service
  import ski_fetch_service_pkg::*;
(
  input  logic                system1000,
  input  logic                system1000_rstn,
  ski_fetch_service_if.slave  bus
);

  state_e             r_state, w_state_nxt;
  frame_t             r_frame, w_frame_nxt;
  logic [NSLOT-1:0]   r_pend, w_pend_nxt, w_pick_in, w_cur_oh;
  logic [IDX_W-1:0]   r_cur, w_cur_nxt, w_pick_idx;
  logic               w_pick_any;
  logic [PTR_W-1:0]   r_rd_addr, w_addr_nxt;
  logic               r_req_ready, r_rd_valid, r_out_valid, r_busy, r_stray;
  logic               w_accept, w_stray_nxt;

  // In WAIT the picker looks ahead to the next slot; otherwise it scans the incoming frame.
  assign w_cur_oh  = NSLOT'(1) << r_cur;
  assign w_pick_in = (r_state == ST_WAIT) ? (r_pend & ~w_cur_oh)
                                          : pend_mask(bus.req_frame_i);
  assign w_accept  = r_req_ready && bus.req_valid_i;

  ski_prio_pick u_pick (
    .i_req   (w_pick_in),
    .o_idx_c (w_pick_idx),
    .o_any_c (w_pick_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_frame_nxt = r_frame;
    w_pend_nxt  = r_pend;
    w_cur_nxt   = r_cur;
    w_addr_nxt  = r_rd_addr;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_frame_nxt = bus.req_frame_i;
          w_pend_nxt  = w_pick_in;
          w_cur_nxt   = w_pick_idx;
          w_addr_nxt  = slot_ptr(bus.req_frame_i[w_pick_idx].payload);
          w_state_nxt = w_pick_any ? ST_ISSUE : ST_DONE;
        end
      end
      ST_ISSUE: begin
        if (bus.mem_rd_ready_i) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid_i) begin
          w_frame_nxt[r_cur] = {TAG_FILL, bus.mem_rsp_data_i};
          w_pend_nxt         = w_pick_in;
          w_cur_nxt          = w_pick_idx;
          if (w_pick_any) begin
            w_addr_nxt  = slot_ptr(r_frame[w_pick_idx].payload);
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.out_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A response is only legal while a read is outstanding.
  assign w_stray_nxt = r_stray || (bus.mem_rsp_valid_i && (r_state != ST_WAIT));

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) r_state <= ST_IDLE;
    else                  r_state <= w_state_nxt;
  end

  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      r_frame     <= '0;
      r_pend      <= '0;
      r_cur       <= '0;
      r_rd_addr   <= '0;
      r_req_ready <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_stray     <= 1'b0;
    end else begin
      r_frame     <= w_frame_nxt;
      r_pend      <= w_pend_nxt;
      r_cur       <= w_cur_nxt;
      r_rd_addr   <= w_addr_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rd_valid  <= (w_state_nxt == ST_ISSUE);
      r_out_valid <= (w_state_nxt == ST_DONE);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_stray     <= w_stray_nxt;
    end
  end

  assign bus.req_ready_o    = r_req_ready;
  assign bus.mem_rd_valid_o = r_rd_valid;
  assign bus.mem_rd_addr_o  = r_rd_addr;
  assign bus.out_valid_o    = r_out_valid;
  assign bus.out_frame_o    = r_frame;
  assign bus.busy_o         = r_busy;
  assign bus.stray_rsp_o    = r_stray;

endmodule
